// File: rtl/load_store_unit.sv
// Memory-access stage: big-endian lane placement for stores, in-order load tracking
// with a metadata FIFO, registered sign/zero-extended writeback, error and access counters.
module load_store_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_load,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [4:0]          req_rd,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_bytemask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_rdata,
    output logic                wb_valid,
    output logic [4:0]          wb_rd,
    output logic [DATA_W-1:0]   wb_data,
    output logic                stall,
    output logic                misalign_err,
    output logic [ADDR_W-1:0]   err_addr,
    output logic                proto_err,
    output logic [CNT_W-1:0]    load_count,
    output logic [CNT_W-1:0]    store_count
);
    localparam int unsigned WB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(WB);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [OFF_W-1:0]  req_off;
    logic              misaligned;
    logic              is_store;
    logic              slot_free;
    logic              mem_hs;
    logic              push;
    logic              pop;
    logic              mis_accept;

    int unsigned       st_nbytes;
    int unsigned       st_shift;
    logic [DATA_W-1:0] st_size_mask;
    logic [WB-1:0]     st_lane_mask;

    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    count_q;
    logic [PTR_W:0]    count_d;

    logic [4:0]        meta_rd     [DEPTH];
    logic [1:0]        meta_size   [DEPTH];
    logic              meta_signed [DEPTH];
    logic [OFF_W-1:0]  meta_off    [DEPTH];

    logic [OFF_W-1:0]  ld_off;
    logic [1:0]        ld_size;
    logic              ld_signed;
    int unsigned       ld_nbytes;
    int unsigned       ld_shift;
    logic [DATA_W-1:0] ld_field_mask;
    logic [DATA_W-1:0] ld_top_bit;
    logic [DATA_W-1:0] ld_field;
    logic [DATA_W-1:0] ld_data;

    assign req_off  = req_addr[OFF_W-1:0];
    assign is_store = !req_load;

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_off[0];
            2'd2:    misaligned = (req_off[1:0] != 2'b00);
            default: misaligned = (DATA_W == 32) || (req_off != '0);
        endcase
    end

    // Field of st_nbytes bytes starting at offset k sits just below bit DATA_W-8k.
    always_comb begin
        st_nbytes    = 32'(1) << req_size;
        st_shift     = 0;
        st_size_mask = '1;
        st_lane_mask = '0;
        if (!misaligned) begin
            st_shift = (WB - 32'(req_off) - st_nbytes) * 8;
            if (st_nbytes < WB) begin
                st_size_mask = (DATA_W'(1) << (st_nbytes * 8)) - DATA_W'(1);
            end
            st_lane_mask = WB'(((32'(1) << st_nbytes) - 32'd1)
                                << (WB - 32'(req_off) - st_nbytes));
        end
    end

    assign slot_free = (count_q < FULL_CNT) || ((count_q == FULL_CNT) && mem_resp_valid);

    assign mem_req_valid = req_valid && !misaligned && (is_store || slot_free);
    assign req_ready     = req_valid && (misaligned || (mem_req_ready && (is_store || slot_free)));
    assign stall         = req_valid && !req_ready;
    assign mem_we        = req_valid && is_store;
    assign mem_addr      = req_valid ? {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign mem_wdata     = (req_valid && is_store) ? ((req_wdata & st_size_mask) << st_shift) : '0;
    assign mem_bytemask  = !req_valid ? '0 : (req_load ? '1 : st_lane_mask);

    assign mem_hs     = mem_req_valid && mem_req_ready;
    assign push       = mem_hs && req_load;
    assign pop        = mem_resp_valid && (count_q != '0);
    assign mis_accept = req_valid && misaligned;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Metadata storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge CLK) begin
        if (push) begin
            meta_rd[wr_ptr_q]     <= req_rd;
            meta_size[wr_ptr_q]   <= req_size;
            meta_signed[wr_ptr_q] <= req_signed;
            meta_off[wr_ptr_q]    <= req_off;
        end
    end

    always_comb begin
        ld_off        = meta_off[rd_ptr_q];
        ld_size       = meta_size[rd_ptr_q];
        ld_signed     = meta_signed[rd_ptr_q];
        ld_nbytes     = 32'(1) << ld_size;
        ld_shift      = (WB - 32'(ld_off) - ld_nbytes) * 8;
        ld_field_mask = '1;
        if (ld_nbytes < WB) begin
            ld_field_mask = (DATA_W'(1) << (ld_nbytes * 8)) - DATA_W'(1);
        end
        ld_top_bit = ld_field_mask ^ (ld_field_mask >> 1);
        ld_field   = (mem_resp_rdata >> ld_shift) & ld_field_mask;
        ld_data    = ld_field;
        if (ld_signed && ((ld_field & ld_top_bit) != '0)) begin
            ld_data = ld_field | ~ld_field_mask;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            misalign_err <= 1'b0;
            err_addr     <= '0;
            proto_err    <= 1'b0;
            load_count   <= '0;
            store_count  <= '0;
        end else begin
            wb_valid     <= pop;
            misalign_err <= mis_accept;
            if (pop) begin
                wb_rd   <= meta_rd[rd_ptr_q];
                wb_data <= ld_data;
            end
            if (mis_accept) err_addr <= req_addr;
            if (mem_resp_valid && (count_q == '0)) proto_err <= 1'b1;
            if (push && (load_count != '1)) load_count <= load_count + CNT_W'(1);
            if (mem_hs && is_store && (store_count != '1)) begin
                store_count <= store_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (DATA_W=32, DEPTH=4): directed scenarios plus a
// randomized run against a byte-level reference model.
module tb_load_store_unit;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int WB    = DW / 8;
    localparam int DEPTH = 4;

    logic          CLK = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_load = 1'b0;
    logic [1:0]    req_size = 2'd0;
    logic          req_signed = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [4:0]    req_rd = '0;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [WB-1:0] mem_bytemask;
    logic          mem_resp_valid = 1'b0;
    logic [DW-1:0] mem_resp_rdata = '0;
    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic [DW-1:0] wb_data;
    logic          stall;
    logic          misalign_err;
    logic [AW-1:0] err_addr;
    logic          proto_err;
    logic [31:0]   load_count;
    logic [31:0]   store_count;

    int total = 0;
    int bad   = 0;
    int exp_loads  = 0;
    int exp_stores = 0;

    typedef struct {
        logic [4:0] rd;
        int         n;
        int         k;
        bit         sgn;
    } ld_t;

    always #5 CLK = ~CLK;

    load_store_unit #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .CNT_W(32)) dut (
        .CLK(CLK), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_bytemask(mem_bytemask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
        .misalign_err(misalign_err), .err_addr(err_addr), .proto_err(proto_err),
        .load_count(load_count), .store_count(store_count)
    );

    // Reference: gather bytes k..k+n-1 in address order, then extend.
    function automatic logic [DW-1:0] model_load(logic [DW-1:0] word, int k, int n, bit sgn);
        logic [DW-1:0] v = '0;
        logic [DW-1:0] byte_v;
        for (int j = 0; j < n; j++) begin
            byte_v = (word >> (8 * (WB - 1 - (k + j)))) & 32'hFF;
            v = (v << 8) | byte_v;
        end
        if (sgn && v[8*n-1]) begin
            for (int b = 8 * n; b < DW; b++) v[b] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [DW-1:0] model_store(logic [DW-1:0] wd, int k, int n);
        logic [DW-1:0] r = '0;
        logic [DW-1:0] byte_v;
        for (int j = 0; j < n; j++) begin
            byte_v = (wd >> (8 * (n - 1 - j))) & 32'hFF;
            r = r | (byte_v << (8 * (WB - 1 - (k + j))));
        end
        return r;
    endfunction

    function automatic logic [WB-1:0] model_mask(int k, int n);
        logic [WB-1:0] m = '0;
        for (int j = 0; j < n; j++) m[WB-1-(k+j)] = 1'b1;
        return m;
    endfunction

    function automatic bit model_mis(int size, int k);
        return (size == 1 && (k % 2) != 0) || (size == 2 && (k % 4) != 0) ||
               (size == 3 && (DW == 32 || k != 0));
    endfunction

    task automatic set_req(bit v, bit ld, int size, bit sgn, logic [AW-1:0] a,
                           logic [DW-1:0] wd, logic [4:0] rd);
        req_valid  = v;
        req_load   = ld;
        req_size   = size[1:0];
        req_signed = sgn;
        req_addr   = a;
        req_wdata  = wd;
        req_rd     = rd;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #2;
        total++;
        if ({wb_valid, wb_rd, wb_data, misalign_err, err_addr, proto_err} !== '0) begin
            bad++;
            $display("FAIL reset_regs: got wb_valid=%b wb_rd=%0d wb_data=%h me=%b ea=%h pe=%b want all 0",
                     wb_valid, wb_rd, wb_data, misalign_err, err_addr, proto_err);
        end
        total++;
        if ({load_count, store_count} !== '0) begin
            bad++;
            $display("FAIL reset_counts: got %0d/%0d want 0/0", load_count, store_count);
        end
        total++;
        if ({req_ready, mem_req_valid, stall, mem_we, mem_addr, mem_wdata, mem_bytemask} !== '0) begin
            bad++;
            $display("FAIL idle_comb: got rdy=%b mv=%b st=%b we=%b a=%h d=%h m=%b want all 0",
                     req_ready, mem_req_valid, stall, mem_we, mem_addr, mem_wdata, mem_bytemask);
        end
        @(negedge CLK);
        reset = 1'b0;
    endtask

    task automatic test_store;
        @(negedge CLK);
        set_req(1, 0, 0, 0, 32'h1001, 32'h000000AB, 5'd0);
        mem_req_ready = 1'b1;
        #1;
        total++;
        if (mem_addr !== 32'h1000 || mem_wdata !== 32'h00AB0000 || mem_bytemask !== 4'b0100) begin
            bad++;
            $display("FAIL sb_lanes: got a=%h d=%h m=%b want 00001000 00ab0000 0100",
                     mem_addr, mem_wdata, mem_bytemask);
        end
        total++;
        if (mem_req_valid !== 1'b1 || mem_we !== 1'b1 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL sb_handshake: got mv=%b we=%b rdy=%b want 1 1 1",
                     mem_req_valid, mem_we, req_ready);
        end
        @(posedge CLK);
        exp_stores++;
        #1;
        total++;
        if (store_count !== 32'(exp_stores)) begin
            bad++;
            $display("FAIL sb_count: got %0d want %0d", store_count, exp_stores);
        end
        @(negedge CLK);
        set_req(0, 0, 0, 0, '0, '0, '0);
        mem_req_ready = 1'b0;
    endtask

    task automatic do_load(int size, bit sgn, logic [AW-1:0] a, logic [4:0] rd,
                           logic [DW-1:0] word, logic [DW-1:0] want, string name);
        @(negedge CLK);
        set_req(1, 1, size, sgn, a, 32'hDEADBEEF, rd);
        mem_req_ready = 1'b1;
        #1;
        total++;
        if (mem_req_valid !== 1'b1 || mem_we !== 1'b0 || mem_wdata !== '0 || mem_bytemask !== 4'hF) begin
            bad++;
            $display("FAIL %s_req: got mv=%b we=%b d=%h m=%b want 1 0 0 1111",
                     name, mem_req_valid, mem_we, mem_wdata, mem_bytemask);
        end
        @(posedge CLK);
        exp_loads++;
        @(negedge CLK);
        set_req(0, 0, 0, 0, '0, '0, '0);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = word;
        @(posedge CLK);
        #1;
        total++;
        if (wb_valid !== 1'b1 || wb_rd !== rd || wb_data !== want) begin
            bad++;
            $display("FAIL %s_wb: got v=%b rd=%0d d=%h want 1 %0d %h", name, wb_valid, wb_rd,
                     wb_data, rd, want);
        end
        @(negedge CLK);
        mem_resp_valid = 1'b0;
        @(posedge CLK);
        #1;
        total++;
        if (wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_pulse: got wb_valid=%b want 0", name, wb_valid);
        end
    endtask

    task automatic test_load;
        do_load(1, 1, 32'h2, 5'd3, 32'h8899AABB, 32'hFFFFAABB, "lh");
        do_load(0, 0, 32'h1, 5'd9, 32'h8899AABB, 32'h00000099, "lbu");
        total++;
        if (load_count !== 32'(exp_loads)) begin
            bad++;
            $display("FAIL ld_count: got %0d want %0d", load_count, exp_loads);
        end
    endtask

    task automatic test_misaligned;
        logic [AW-1:0] addrs [3];
        addrs[0] = 32'h3;
        addrs[1] = 32'h11;
        addrs[2] = 32'h22;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            set_req(1, i != 2, (i == 1) ? 1 : 2, 0, addrs[i], '0, 5'd1);
            mem_req_ready = 1'b0;
            #1;
            total++;
            if (mem_req_valid !== 1'b0 || req_ready !== 1'b1 || stall !== 1'b0) begin
                bad++;
                $display("FAIL mis_comb%0d: got mv=%b rdy=%b st=%b want 0 1 0", i,
                         mem_req_valid, req_ready, stall);
            end
            @(posedge CLK);
            #1;
            total++;
            if (misalign_err !== 1'b1 || err_addr !== addrs[i]) begin
                bad++;
                $display("FAIL mis_pulse%0d: got me=%b ea=%h want 1 %h", i, misalign_err,
                         err_addr, addrs[i]);
            end
        end
        @(negedge CLK);
        set_req(0, 0, 0, 0, '0, '0, '0);
        @(posedge CLK);
        #1;
        total++;
        if (misalign_err !== 1'b0 || load_count !== 32'(exp_loads) ||
            store_count !== 32'(exp_stores)) begin
            bad++;
            $display("FAIL mis_after: got me=%b lc=%0d sc=%0d want 0 %0d %0d", misalign_err,
                     load_count, store_count, exp_loads, exp_stores);
        end
    endtask

    task automatic test_backpressure;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            set_req(1, 1, 2, 0, 32'(i * 4), '0, 5'(10 + i));
            @(posedge CLK);
            exp_loads++;
        end
        @(negedge CLK);
        set_req(1, 1, 2, 0, 32'h40, '0, 5'd14);
        #1;
        total++;
        if (stall !== 1'b1 || req_ready !== 1'b0 || mem_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_full: got st=%b rdy=%b mv=%b want 1 0 0", stall, req_ready,
                     mem_req_valid);
        end
        @(posedge CLK);
        @(negedge CLK);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h11111111;
        #1;
        total++;
        if (stall !== 1'b0 || req_ready !== 1'b1 || mem_req_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_popfree: got st=%b rdy=%b mv=%b want 0 1 1", stall, req_ready,
                     mem_req_valid);
        end
        @(posedge CLK);
        exp_loads++;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (wb_valid !== 1'b1 || wb_rd !== 5'(10 + i)) begin
                bad++;
                $display("FAIL bp_drain%0d: got v=%b rd=%0d want 1 %0d", i, wb_valid, wb_rd, 10 + i);
            end
            @(negedge CLK);
            set_req(0, 0, 0, 0, '0, '0, '0);
            mem_resp_rdata = 32'(i);
            @(posedge CLK);
        end
        #1;
        total++;
        if (wb_valid !== 1'b1 || wb_rd !== 5'd14 || wb_data !== 32'd3) begin
            bad++;
            $display("FAIL bp_fifth: got v=%b rd=%0d d=%h want 1 14 3", wb_valid, wb_rd, wb_data);
        end
        @(negedge CLK);
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b0;
        total++;
        if (load_count !== 32'(exp_loads) || proto_err !== 1'b0) begin
            bad++;
            $display("FAIL bp_count: got lc=%0d pe=%b want %0d 0", load_count, proto_err, exp_loads);
        end
    endtask

    task automatic test_random;
        ld_t q[$];
        ld_t e;
        ld_t head;
        int k, n, sz;
        bit mis, exp_mv, exp_rdy, resp, exp_wbv;
        logic [DW-1:0] exp_wbd;
        logic [4:0] exp_wbr;
        for (int c = 0; c < 400 || q.size() > 0; c++) begin
            @(negedge CLK);
            sz = $urandom_range(0, 3);
            set_req((c < 400) && ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), sz,
                    1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(0, 31)));
            mem_req_ready  = ($urandom_range(0, 3) != 0);
            resp           = (q.size() > 0) && ((c >= 400) || ($urandom_range(0, 1) == 1));
            mem_resp_valid = resp;
            mem_resp_rdata = $urandom;
            k   = int'(req_addr[1:0]);
            n   = 1 << sz;
            mis = model_mis(sz, k);
            exp_mv  = req_valid && !mis &&
                      (!req_load || q.size() < DEPTH || (q.size() == DEPTH && resp));
            exp_rdy = req_valid && (mis || (mem_req_ready && exp_mv));
            #1;
            total++;
            if (req_ready !== exp_rdy || mem_req_valid !== exp_mv || stall !== (req_valid && !exp_rdy)) begin
                bad++;
                $display("FAIL rnd_hs c=%0d: got rdy=%b mv=%b st=%b want %b %b %b", c, req_ready,
                         mem_req_valid, stall, exp_rdy, exp_mv, req_valid && !exp_rdy);
            end
            if (exp_mv && !req_load) begin
                total++;
                if (mem_wdata !== model_store(req_wdata, k, n) || mem_bytemask !== model_mask(k, n) ||
                    mem_addr !== {req_addr[AW-1:2], 2'b00}) begin
                    bad++;
                    $display("FAIL rnd_store c=%0d: got a=%h d=%h m=%b want %h %h %b", c, mem_addr,
                             mem_wdata, mem_bytemask, {req_addr[AW-1:2], 2'b00},
                             model_store(req_wdata, k, n), model_mask(k, n));
                end
            end
            exp_wbv = resp;
            exp_wbd = '0;
            exp_wbr = '0;
            if (resp) begin
                head    = q.pop_front();
                exp_wbd = model_load(mem_resp_rdata, head.k, head.n, head.sgn);
                exp_wbr = head.rd;
            end
            if (exp_mv && mem_req_ready) begin
                if (req_load) begin
                    e.rd = req_rd; e.n = n; e.k = k; e.sgn = req_signed;
                    q.push_back(e);
                    exp_loads++;
                end else begin
                    exp_stores++;
                end
            end
            @(posedge CLK);
            #1;
            total++;
            if (wb_valid !== exp_wbv || (exp_wbv && (wb_rd !== exp_wbr || wb_data !== exp_wbd))) begin
                bad++;
                $display("FAIL rnd_wb c=%0d: got v=%b rd=%0d d=%h want %b %0d %h", c, wb_valid,
                         wb_rd, wb_data, exp_wbv, exp_wbr, exp_wbd);
            end
            total++;
            if (misalign_err !== (req_valid && mis) || load_count !== 32'(exp_loads) ||
                store_count !== 32'(exp_stores) || proto_err !== 1'b0) begin
                bad++;
                $display("FAIL rnd_state c=%0d: got me=%b lc=%0d sc=%0d pe=%b want %b %0d %0d 0",
                         c, misalign_err, load_count, store_count, proto_err, req_valid && mis,
                         exp_loads, exp_stores);
            end
        end
        @(negedge CLK);
        set_req(0, 0, 0, 0, '0, '0, '0);
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b0;
    endtask

    task automatic test_ordering;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            set_req(1, 1, 2, 0, 32'h100, '0, 5'(5 + i));
            @(posedge CLK);
            exp_loads++;
        end
        @(negedge CLK);
        set_req(0, 0, 0, 0, '0, '0, '0);
        mem_resp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_resp_rdata = 32'(100 + i);
            @(posedge CLK);
            #1;
            total++;
            if (wb_valid !== 1'b1 || wb_rd !== 5'(5 + i) || wb_data !== 32'(100 + i)) begin
                bad++;
                $display("FAIL order%0d: got v=%b rd=%0d d=%0d want 1 %0d %0d", i, wb_valid, wb_rd,
                         wb_data, 5 + i, 100 + i);
            end
            @(negedge CLK);
        end
        @(posedge CLK);
        #1;
        total++;
        if (proto_err !== 1'b1 || wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL unsolicited: got pe=%b wbv=%b want 1 0", proto_err, wb_valid);
        end
        @(negedge CLK);
        mem_resp_valid = 1'b0;
        @(posedge CLK);
        #1;
        total++;
        if (proto_err !== 1'b1) begin
            bad++;
            $display("FAIL proto_sticky: got %b want 1", proto_err);
        end
    endtask

    task automatic test_reset_midflight;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            set_req(1, 1, 2, 0, 32'h200, '0, 5'd20);
            @(posedge CLK);
        end
        #2;
        set_req(0, 0, 0, 0, '0, '0, '0);
        reset = 1'b1;
        #1;
        total++;
        if ({wb_valid, wb_rd, wb_data, misalign_err, err_addr, proto_err, load_count, store_count} !== '0) begin
            bad++;
            $display("FAIL async_reset: got wbv=%b rd=%0d d=%h me=%b ea=%h pe=%b lc=%0d sc=%0d want all 0",
                     wb_valid, wb_rd, wb_data, misalign_err, err_addr, proto_err, load_count,
                     store_count);
        end
        @(negedge CLK);
        reset = 1'b0;
        exp_loads  = 0;
        exp_stores = 0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        @(posedge CLK);
        #1;
        total++;
        if (proto_err !== 1'b1 || wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL stray_after_reset: got pe=%b wbv=%b want 1 0", proto_err, wb_valid);
        end
        @(negedge CLK);
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        test_reset;
        test_store;
        test_load;
        test_misaligned;
        test_backpressure;
        test_random;
        test_ordering;
        test_reset_midflight;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish want finish before 2000000");
        $fatal(1);
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Parametrised memory-access stage for the MIPS150 pipeline.
- Accepts load/store requests from the execute stage and applies big-endian byte-lane placement and masking to store data.
- Issues word-aligned requests to a ready/valid memory port and tracks up to DEPTH outstanding loads in order.
- Returns sign- or zero-extended load data to writeback, and generates stall, misalignment error and access counters.

Parameters:
DATA_W, 32, memory word width in bits; legal values 32 or 64; WB = DATA_W/8.
ADDR_W, 32, byte-address width.
DEPTH, 4, maximum outstanding loads; power of 2, at least 2.
CNT_W, 32, width of the load and store counters.

Ports:
CLK  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid  in  1  execute-stage request valid
req_ready  out  1  request accepted this cycle when high together with req_valid
req_load  in  1  1 = load, 0 = store
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double (DATA_W=64 only)
req_signed  in  1  sign-extend load result
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-justified
req_rd  in  5  load destination register
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_we  out  1  write enable
mem_addr  out  ADDR_W  req_addr with low log2(WB) bits zeroed
mem_wdata  out  DATA_W  lane-placed store data
mem_bytemask  out  WB  byte enables; bit WB-1-k enables byte offset k
mem_resp_valid  in  1  load response valid (in order)
mem_resp_rdata  in  DATA_W  load response word
wb_valid  out  1  writeback valid, one-cycle pulse
wb_rd  out  5  writeback register
wb_data  out  DATA_W  extended load data
stall  out  1  req_valid and not req_ready
misalign_err  out  1  one-cycle pulse, cycle after a misaligned request is accepted
err_addr  out  ADDR_W  address of the last misaligned request
proto_err  out  1  sticky; response arrived with no outstanding load
load_count  out  CNT_W  loads issued; saturates
store_count  out  CNT_W  stores issued; saturates

Behaviour:
- Byte order is big-endian: offset k = req_addr[log2(WB)-1:0]; byte k occupies bits [DATA_W-1-8k -: 8].
- Misaligned: half with k odd, word with k not a multiple of 4, double with k not 0, or size 3 when DATA_W=32. Misaligned requests never reach memory.
- Path is combinational: mem_req_valid = req_valid and not misaligned and (store or slot_free).
- slot_free = count < DEPTH, or (count == DEPTH and mem_resp_valid), so a pop frees a slot in the same cycle.
- req_ready = misaligned, or (mem_req_ready and (store or slot_free)).
- Stores: size-wide data is shifted into lanes k..k+size_bytes-1; other lanes are 0; mask is set only for those lanes.
- Loads: mem_wdata = 0, mask = all ones. On handshake, {rd, size, signed, k} is pushed into the metadata FIFO.
- Responses: on mem_resp_valid with the FIFO non-empty, pop the FIFO; extract the field at offset k and sign- or zero-extend it to DATA_W.
- Writeback is registered: wb_valid, wb_rd and wb_data update at the next CLK edge. Load latency from response to wb_valid is exactly 1 cycle.
- Response with the FIFO empty: data is dropped, proto_err is set, and it clears only on reset.
- Push and pop in the same cycle: count is unchanged; FIFO pointers wrap modulo DEPTH.
- Counters increment once per accepted non-misaligned memory handshake and hold at all-ones.
- On misaligned accept: err_addr <= req_addr and misalign_err pulses for 1 cycle. Back-to-back misaligned requests give consecutive pulses.
- Reset (asynchronous, active high) clears FIFO pointers, count, wb_valid, wb_rd, wb_data, misalign_err, err_addr, proto_err and both counters to 0. Loads in flight are abandoned.
- After reset deasserts, responses with the FIFO empty set proto_err.
- Combinational outputs are 0 while req_valid = 0.

Test Plan:
- Store: DATA_W=32, byte store, addr 0x1001, wdata 0x000000AB -> mem_addr 0x1000, mem_wdata 0x00AB0000, mask 0100, store_count 1.
- Load: mem 0x8899AABB, LH signed at addr 0x2 -> wb_data 0xFFFFAABB one cycle after the response. LBU at addr 0x1 -> 0x00000099.
- Misaligned: LW at 0x3 -> no mem_req_valid, req_ready=1, misalign_err pulse, err_addr=0x3, load_count unchanged.
- Backpressure: DEPTH=4, 4 loads with no response -> 5th load gives stall=1. Fifth load presented with a simultaneous response -> accepted that cycle, count stays 4.
- Ordering: 3 loads to rd 5, 6, 7, responses on consecutive cycles -> wb_rd 5, 6, 7 in order; unsolicited 4th response -> proto_err=1.
- Reset: assert reset mid-operation with 2 loads outstanding -> all outputs 0 asynchronously; after release, a stray response sets proto_err.
